// File: rtl/vram_bus_arbiter.sv
// rtl/vram_bus_arbiter.sv - single-port VRAM arbiter between the uPD7801 bus and the video fetch engine
module vram_bus_arbiter #(
    parameter int          AW         = 11,
    parameter logic [15:0] BASE       = 16'h2000,
    parameter int          CPU_STARVE = 8
) (
    input  logic          CLK,
    input  logic          RESETB,
    input  logic [15:0]   CPU_A,
    input  logic [7:0]    CPU_DB_O,
    output logic [7:0]    CPU_DB_I,
    input  logic          CPU_RDB,
    input  logic          CPU_WRB,
    output logic          CPU_WAITB,
    input  logic          VID_REQ,
    input  logic [AW-1:0] VID_ADDR,
    output logic          VID_ACK,
    output logic [7:0]    VID_DATA,
    output logic          MEM_CE,
    output logic          MEM_WE,
    output logic [AW-1:0] MEM_A,
    output logic [7:0]    MEM_DO,
    input  logic [7:0]    MEM_DI
);

    localparam int SW = $clog2(CPU_STARVE + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(CPU_STARVE);

    // Window bounds held in 17 bits so BASE near the top of the map cannot wrap.
    localparam logic [16:0] WIN_LO = {1'b0, BASE};
    localparam logic [16:0] WIN_HI = WIN_LO + 17'(1 << AW) - 17'd1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CPU_WR  = 3'd1;
    localparam logic [2:0] S_CPU_RD  = 3'd2;
    localparam logic [2:0] S_CPU_RDD = 3'd3;
    localparam logic [2:0] S_VID_RD  = 3'd4;
    localparam logic [2:0] S_VID_RDD = 3'd5;

    logic [2:0]    state_q, state_d;
    logic          mem_ce_q, mem_ce_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_a_q, mem_a_d;
    logic [7:0]    mem_do_q, mem_do_d;
    logic [7:0]    cpu_rdata_q, cpu_rdata_d;
    logic [7:0]    vid_data_q, vid_data_d;
    logic          vid_ack_q, vid_ack_d;
    logic          served_q, served_d;
    logic [SW-1:0] starve_q, starve_d;

    logic in_win;
    logic hit;
    logic cpu_done;
    logic served_w;
    logic pending;
    logic cpu_grant;
    logic vid_busy;

    assign in_win = ({1'b0, CPU_A} >= WIN_LO) && ({1'b0, CPU_A} <= WIN_HI);
    assign hit    = in_win && (!CPU_RDB || !CPU_WRB);

    // The completing cycle already counts as served, so WAITB releases in the
    // same cycle the write strobes the RAM or the read data is captured.
    assign cpu_done = (state_q == S_CPU_WR) || (state_q == S_CPU_RDD);
    assign served_w = served_q || cpu_done;
    assign pending  = hit && !served_w;

    assign CPU_WAITB = !pending || !RESETB;

    // Next-state decode; the memory strobes are computed one cycle early so
    // they come straight from flops during the access cycle itself.
    always_comb begin
        state_d  = state_q;
        mem_ce_d = 1'b0;
        mem_we_d = 1'b0;
        mem_a_d  = mem_a_q;
        mem_do_d = mem_do_q;
        case (state_q)
            S_IDLE: begin
                if (pending && (!VID_REQ || (starve_q >= STARVE_MAX))) begin
                    mem_ce_d = 1'b1;
                    mem_a_d  = CPU_A[AW-1:0];
                    if (!CPU_WRB) begin
                        state_d  = S_CPU_WR;
                        mem_we_d = 1'b1;
                        mem_do_d = CPU_DB_O;
                    end else begin
                        state_d  = S_CPU_RD;
                    end
                end else if (VID_REQ) begin
                    state_d  = S_VID_RD;
                    mem_ce_d = 1'b1;
                    mem_a_d  = VID_ADDR;
                end
            end
            S_CPU_WR:  state_d = S_IDLE;
            S_CPU_RD:  state_d = S_CPU_RDD;
            S_CPU_RDD: state_d = S_IDLE;
            S_VID_RD:  state_d = S_VID_RDD;
            S_VID_RDD: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    assign cpu_grant = (state_q == S_IDLE) &&
                       ((state_d == S_CPU_WR) || (state_d == S_CPU_RD));
    assign vid_busy  = ((state_q == S_IDLE) && (state_d == S_VID_RD)) ||
                       (state_q == S_VID_RD) || (state_q == S_VID_RDD);

    // Bookkeeping: starvation count, one-access-per-strobe flag, captured read data.
    always_comb begin
        starve_d = starve_q;
        if (!pending || cpu_grant) begin
            starve_d = '0;
        end else if (vid_busy && (starve_q < STARVE_MAX)) begin
            starve_d = starve_q + SW'(1);
        end

        served_d = served_q;
        if (cpu_done) begin
            served_d = 1'b1;
        end else if (CPU_RDB && CPU_WRB) begin
            served_d = 1'b0;
        end

        cpu_rdata_d = (state_q == S_CPU_RDD) ? MEM_DI : cpu_rdata_q;
        vid_data_d  = (state_q == S_VID_RDD) ? MEM_DI : vid_data_q;
        vid_ack_d   = (state_q == S_VID_RDD);
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge CLK) begin
        if (!RESETB) begin
            state_q     <= S_IDLE;
            mem_ce_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_a_q     <= '0;
            mem_do_q    <= 8'h00;
            cpu_rdata_q <= 8'h00;
            vid_data_q  <= 8'h00;
            vid_ack_q   <= 1'b0;
            served_q    <= 1'b0;
            starve_q    <= '0;
        end else begin
            state_q     <= state_d;
            mem_ce_q    <= mem_ce_d;
            mem_we_q    <= mem_we_d;
            mem_a_q     <= mem_a_d;
            mem_do_q    <= mem_do_d;
            cpu_rdata_q <= cpu_rdata_d;
            vid_data_q  <= vid_data_d;
            vid_ack_q   <= vid_ack_d;
            served_q    <= served_d;
            starve_q    <= starve_d;
        end
    end

    assign MEM_CE   = mem_ce_q;
    assign MEM_WE   = mem_we_q;
    assign MEM_A    = mem_a_q;
    assign MEM_DO   = mem_do_q;
    assign CPU_DB_I = cpu_rdata_q;
    assign VID_DATA = vid_data_q;
    assign VID_ACK  = vid_ack_q;

endmodule

// File: tb/tb_vram_bus_arbiter.sv
// tb/tb_vram_bus_arbiter.sv - scoreboard bench for vram_bus_arbiter
module tb_vram_bus_arbiter;

    localparam int AW = 11;

    logic          CLK;
    logic          RESETB;
    logic [15:0]   CPU_A;
    logic [7:0]    CPU_DB_O;
    logic [7:0]    CPU_DB_I;
    logic          CPU_RDB;
    logic          CPU_WRB;
    logic          CPU_WAITB;
    logic          VID_REQ;
    logic [AW-1:0] VID_ADDR;
    logic          VID_ACK;
    logic [7:0]    VID_DATA;
    logic          MEM_CE;
    logic          MEM_WE;
    logic [AW-1:0] MEM_A;
    logic [7:0]    MEM_DO;
    logic [7:0]    MEM_DI;

    vram_bus_arbiter #(.AW(AW), .BASE(16'h2000), .CPU_STARVE(8)) dut (
        .CLK(CLK), .RESETB(RESETB),
        .CPU_A(CPU_A), .CPU_DB_O(CPU_DB_O), .CPU_DB_I(CPU_DB_I),
        .CPU_RDB(CPU_RDB), .CPU_WRB(CPU_WRB), .CPU_WAITB(CPU_WAITB),
        .VID_REQ(VID_REQ), .VID_ADDR(VID_ADDR), .VID_ACK(VID_ACK), .VID_DATA(VID_DATA),
        .MEM_CE(MEM_CE), .MEM_WE(MEM_WE), .MEM_A(MEM_A), .MEM_DO(MEM_DO), .MEM_DI(MEM_DI)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ce_cnt = 0;
    int ack_cnt = 0;
    int ack_cyc = 0;
    int wr_cyc = 0;
    bit prev_waitb = 1'b1;
    bit rd_chk = 1'b0;

    logic [7:0]    vram [0:2047];
    logic [7:0]    vid_tab [0:7];
    logic [7:0]    rd_q [$];
    logic [18:0]   wr_q [$];
    logic [7:0]    vid_q [$];

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial forever begin
        @(posedge CLK);
        cyc = cyc + 1;
    end

    // VRAM model with registered read data
    initial forever begin
        @(posedge CLK);
        if (MEM_CE === 1'b1) begin
            if (MEM_WE === 1'b1) vram[MEM_A] = MEM_DO;
            else MEM_DI <= vram[MEM_A];
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic flag(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: actual=event required=none", nm);
    endtask

    // Monitor: pops expectations whenever the DUT presents a result
    initial forever begin
        @(negedge CLK);
        if (rd_chk) begin
            rd_chk = 1'b0;
            if (rd_q.size() == 0) flag("cpu_rd_unexpected");
            else check("cpu_rd_data", CPU_DB_I, rd_q.pop_front());
        end
        if (RESETB && !prev_waitb && CPU_WAITB && !CPU_RDB && CPU_WRB) rd_chk = 1'b1;
        prev_waitb = CPU_WAITB;
        if (MEM_CE === 1'b1) ce_cnt++;
        if (MEM_CE === 1'b1 && MEM_WE === 1'b1) begin
            wr_cyc = cyc;
            if (wr_q.size() == 0) flag("mem_wr_unexpected");
            else check("mem_wr_addr_data", {MEM_A, MEM_DO}, wr_q.pop_front());
        end
        if (VID_ACK === 1'b1) begin
            ack_cnt++;
            ack_cyc = cyc;
            if (vid_q.size() == 0) flag("vid_ack_unexpected");
            else check("vid_data", VID_DATA, vid_q.pop_front());
        end
    end

    // One CPU strobe; d is write data or the expected read byte
    task automatic cpu_op(input logic [15:0] a, input logic rdl, input logic wrl,
                          input logic [7:0] d, input int exp_low, input string nm);
        int  low = 0;
        bit  done = 1'b0;
        bit  inwin;
        inwin = (a >= 16'h2000) && (a <= 16'h27FF);
        if (inwin) begin
            if (wrl) wr_q.push_back({a[10:0], d});
            else if (rdl) rd_q.push_back(d);
        end
        @(posedge CLK); #1;
        CPU_A = a;
        CPU_DB_O = d;
        CPU_RDB = !rdl;
        CPU_WRB = !wrl;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge CLK);
            if (!CPU_WAITB) low++;
            else if (low > 0 || (!inwin && i >= 5)) done = 1'b1;
        end
        if (!done) flag({nm, "_timeout"});
        check({nm, "_wait_cycles"}, low, exp_low);
        @(posedge CLK); #1;
        CPU_RDB = 1'b1;
        CPU_WRB = 1'b1;
    endtask

    // n fetches from consecutive addresses with VID_REQ held between them
    task automatic vid_seq(input logic [AW-1:0] a, input int n, input int gap);
        int got = 0;
        int t0;
        int prev = 0;
        @(posedge CLK); #1;
        t0 = cyc;
        VID_ADDR = a;
        vid_q.push_back(vid_tab[int'(a) - 16]);
        VID_REQ = 1'b1;
        for (int i = 0; i < 100 && got < n; i++) begin
            @(negedge CLK);
            if (VID_ACK === 1'b1) begin
                got++;
                if (got == 1) check("vid_first_latency", cyc - t0, 3);
                else if (gap != 0) check("vid_ack_spacing", cyc - prev, gap);
                prev = cyc;
                if (got < n) begin
                    VID_ADDR = a + AW'(got);
                    vid_q.push_back(vid_tab[int'(a) - 16 + got]);
                end else begin
                    VID_REQ = 1'b0;
                end
            end
        end
        if (got < n) flag("vid_timeout");
        VID_REQ = 1'b0;
    endtask

    initial begin
        int ce0;
        int ack0;
        vid_tab = '{8'h5A, 8'hC3, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        for (int i = 0; i < 2048; i++) vram[i] = 8'h00;
        for (int i = 0; i < 8; i++) vram[16 + i] = vid_tab[i];
        MEM_DI = 8'h00;
        RESETB = 1'b0;
        CPU_A = 16'h2000;
        CPU_DB_O = 8'h00;
        CPU_RDB = 1'b0;
        CPU_WRB = 1'b1;
        VID_REQ = 1'b0;
        VID_ADDR = '0;

        // Reset with a live in-window read strobe
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_waitb", CPU_WAITB, 1);
        check("rst_mem_ce", MEM_CE, 0);
        check("rst_vid_ack", VID_ACK, 0);
        check("rst_vid_data", VID_DATA, 0);
        check("rst_cpu_db_i", CPU_DB_I, 0);
        @(posedge CLK); #1;
        CPU_RDB = 1'b1;
        @(posedge CLK); #1;
        RESETB = 1'b1;
        repeat (2) @(posedge CLK);

        // Write then read, window top edge, both strobes low
        cpu_op(16'h2123, 1'b0, 1'b1, 8'hA5, 1, "wr_2123");
        cpu_op(16'h2123, 1'b1, 1'b0, 8'hA5, 2, "rd_2123");
        cpu_op(16'h27FF, 1'b0, 1'b1, 8'h3C, 1, "wr_27ff");
        cpu_op(16'h27FF, 1'b1, 1'b0, 8'h3C, 2, "rd_27ff");
        cpu_op(16'h2200, 1'b1, 1'b1, 8'h77, 1, "both_strobes");

        // Outside the window on both sides
        ce0 = ce_cnt;
        cpu_op(16'h1FFF, 1'b1, 1'b0, 8'h00, 0, "rd_1fff");
        cpu_op(16'h2800, 1'b1, 1'b0, 8'h00, 0, "rd_2800");
        check("out_of_window_ce", ce_cnt - ce0, 0);

        // Back-to-back video fetches
        vid_seq(11'h010, 2, 3);
        repeat (3) @(posedge CLK);

        // Starvation: continuous video, CPU read forced in after 8 lost cycles
        ack0 = ack_cnt;
        fork
            vid_seq(11'h012, 5, 0);
            cpu_op(16'h2123, 1'b1, 1'b0, 8'hA5, 11, "starve_rd");
        join
        repeat (4) @(posedge CLK);
        check("starve_ack_count", ack_cnt - ack0, 5);

        // Simultaneous arrival: video first, CPU write the cycle after ACK
        fork
            vid_seq(11'h017, 1, 0);
            cpu_op(16'h2300, 1'b0, 1'b1, 8'h99, 4, "simul_wr");
        join
        check("simul_order", wr_cyc - ack_cyc, 1);
        cpu_op(16'h2300, 1'b1, 1'b0, 8'h99, 2, "rd_2300");

        // Reset during VID_RD abandons the fetch
        ack0 = ack_cnt;
        @(posedge CLK); #1;
        VID_ADDR = 11'h010;
        VID_REQ = 1'b1;
        @(posedge CLK); #1;
        RESETB = 1'b0;
        VID_REQ = 1'b0;
        @(posedge CLK); #1;
        RESETB = 1'b1;
        repeat (6) @(posedge CLK);
        @(negedge CLK);
        check("rst_mid_vid_no_ack", ack_cnt - ack0, 0);
        check("rst_mid_vid_ce", MEM_CE, 0);

        check("rd_queue_drained", rd_q.size(), 0);
        check("wr_queue_drained", wr_q.size(), 0);
        check("vid_queue_drained", vid_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1);
    end

endmodule
